// File: rtl/tlbi_tx_if.sv
// TLBI transmit-side bundle: request, per-target broadcast/ack, done and status.
// The slave modport is the tlbi_tx view; master is the surrounding logic.
interface tlbi_tx_if #(
  parameter int NTGT    = 2,
  parameter int VPN_W   = 27,
  parameter int SPTBR_W = 38
);
  logic               req_valid;
  logic               req_retry;
  logic [1:0]         req_kind;
  logic [VPN_W-1:0]   req_vpn;
  logic [SPTBR_W-1:0] req_sptbr;

  logic [NTGT-1:0]    tlbi_valid;
  logic [NTGT-1:0]    tlbi_retry;
  logic [1:0]         tlbi_kind;
  logic [VPN_W-1:0]   tlbi_vpn;
  logic [SPTBR_W-1:0] tlbi_sptbr;

  logic [NTGT-1:0]    ack_valid;

  logic               done_valid;
  logic               done_retry;

  logic               busy;
  logic               timeout_err;

  modport master (
    output req_valid, req_kind, req_vpn, req_sptbr, tlbi_retry, ack_valid, done_retry,
    input  req_retry, tlbi_valid, tlbi_kind, tlbi_vpn, tlbi_sptbr, done_valid, busy, timeout_err
  );

  modport slave (
    input  req_valid, req_kind, req_vpn, req_sptbr, tlbi_retry, ack_valid, done_retry,
    output req_retry, tlbi_valid, tlbi_kind, tlbi_vpn, tlbi_sptbr, done_valid, busy, timeout_err
  );
endinterface

// File: rtl/tlbi_tx.sv
// TLBI transmit: queues invalidates, broadcasts the head to NTGT TLBs, collects acks, reports done.
// Optional ack timeout is enabled by defining TLBI_TIMEOUT_EN.
module tlbi_tx #(
  parameter int NTGT        = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int VPN_W       = 27,
  parameter int SPTBR_W     = 38,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic      clk,
  input  logic      reset,
  tlbi_tx_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, DONE} state_t;

  state_t             state;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic [NTGT-1:0]    sent_mask, ack_mask;

  logic [1:0]         fifo_kind  [FIFO_DEPTH];
  logic [VPN_W-1:0]   fifo_vpn   [FIFO_DEPTH];
  logic [SPTBR_W-1:0] fifo_sptbr [FIFO_DEPTH];

  logic               full, push, pop, more_after_pop;
  logic [NTGT-1:0]    accept, ack_set, sent_next, ack_next;
  logic               sent_all, ack_all;

`ifdef TLBI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]      tcnt;
  logic               terr;
  logic               tmo_hit;
`endif

  assign full = (count == CW'(FIFO_DEPTH));
  assign push = bus.req_valid && !full;
  assign pop  = (state == DONE) && !bus.done_retry;
  // Occupancy after this cycle's pop, including a same-cycle push.
  assign more_after_pop = (count > CW'(1)) || push;

  always_comb begin
    accept  = '0;
    ack_set = '0;
    if (state == SEND)
      accept = ~sent_mask & ~bus.tlbi_retry;
    // An ack counts only once its target has taken (or is taking) the request.
    if (state == SEND || state == WAIT_ACK)
      ack_set = bus.ack_valid & (sent_mask | accept);
  end

  assign sent_next = sent_mask | accept;
  assign ack_next  = ack_mask | ack_set;
  assign sent_all  = &sent_next;
  assign ack_all   = &ack_next;

`ifdef TLBI_TIMEOUT_EN
  assign tmo_hit = (state == WAIT_ACK) && !ack_all && (tcnt == TW'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_kind[wr_ptr]  <= bus.req_kind;
      fifo_vpn[wr_ptr]   <= bus.req_vpn;
      fifo_sptbr[wr_ptr] <= bus.req_sptbr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      sent_mask <= '0;
      ack_mask  <= '0;
`ifdef TLBI_TIMEOUT_EN
      tcnt      <= '0;
      terr      <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (count != '0) state <= SEND;
        end
        SEND: begin
          sent_mask <= sent_next;
          ack_mask  <= ack_next;
`ifdef TLBI_TIMEOUT_EN
          tcnt      <= '0;
`endif
          if (sent_all) state <= ack_all ? DONE : WAIT_ACK;
        end
        WAIT_ACK: begin
          ack_mask <= ack_next;
`ifdef TLBI_TIMEOUT_EN
          tcnt     <= tcnt + TW'(1);
          if (tmo_hit) begin
            terr  <= 1'b1;
            state <= DONE;
          end
`endif
          if (ack_all) state <= DONE;
        end
        DONE: begin
          if (!bus.done_retry) begin
            sent_mask <= '0;
            ack_mask  <= '0;
            state     <= more_after_pop ? SEND : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_retry  = full;
  assign bus.tlbi_valid = (state == SEND) ? ~sent_mask : '0;
  assign bus.tlbi_kind  = (state != IDLE) ? fifo_kind[rd_ptr]  : '0;
  assign bus.tlbi_vpn   = (state != IDLE) ? fifo_vpn[rd_ptr]   : '0;
  assign bus.tlbi_sptbr = (state != IDLE) ? fifo_sptbr[rd_ptr] : '0;
  assign bus.done_valid = (state == DONE);
  assign bus.busy       = (state != IDLE) || (count != '0);
`ifdef TLBI_TIMEOUT_EN
  assign bus.timeout_err = terr;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule
